dc_motor_pwm_driver: RTL and testbench

Converts the signed 16-bit motor command from the velocity PI stage into a single-ended PWM plus direction signal for the H-bridge. It sits directly downstream of the PI controller's `control_signal`. It enforces:

- period-aligned duty updates;
- a dead interval on every direction reversal;
- a sticky fault shutdown.

All logic runs in the 100 MHz `clk` domain.

---
 rtl/motor_ctrl_pkg.sv | 19 +
 rtl/pwm_period_counter.sv | 28 ++
 rtl/dc_motor_pwm_driver.sv | 82 ++++++++
 tb/tb_dc_motor_pwm_driver.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// motor_ctrl_pkg: shared types, sizes and the command clamp for bridge-facing blocks
// Contents: motor_state_e FSM states, CMD_W command width, PWM_PERIOD_DEFAULT,
//           clamp_mag() returning |cmd| limited to a full-scale value
package motor_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DEAD, HOLD} motor_state_e;

    localparam int CMD_W              = 16;
    localparam int PWM_PERIOD_DEFAULT = 4000;

    // Two's-complement negate in an unsigned result, so -32768 becomes 32768 and then clamps
    function automatic logic [CMD_W-1:0] clamp_mag(input logic signed [CMD_W-1:0] cmd,
                                                   input logic [CMD_W-1:0] limit);
        logic [CMD_W-1:0] a;
        a = cmd[CMD_W-1] ? (~cmd + 1'b1) : cmd;
        return (a > limit) ? limit : a;
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: free-running 0..PERIOD-1 counter with period and sample strobes
// Ports: clk, reset_n (async, active-low) in; cnt count value, period_start (registered,
//        high while cnt == 0 after the first wrap), sample (high while cnt == PERIOD-1) out
module pwm_period_counter
    import motor_ctrl_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [CMD_W-1:0] cnt,
    output logic             period_start,
    output logic             sample
);

    assign sample = (cnt == CMD_W'(PERIOD - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= sample ? '0 : cnt + 1'b1;
            period_start <= sample;
        end
    end

endmodule

// File: rtl/dc_motor_pwm_driver.sv
// dc_motor_pwm_driver: signed motor command to period-aligned PWM + direction with reversal dead interval and sticky fault
// Ports: clk, reset_n (async, active-low), enable, fault, duty_cmd (signed) in;
//        pwm_out, dir_out (1 = reverse), period_start, duty_applied, fault_latched out (all registered)
module dc_motor_pwm_driver
    import motor_ctrl_pkg::*;
#(
    parameter int PERIOD   = PWM_PERIOD_DEFAULT,
    parameter int DEADTIME = 200
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    fault,
    input  logic signed [CMD_W-1:0] duty_cmd,
    output logic                    pwm_out,
    output logic                    dir_out,
    output logic                    period_start,
    output logic        [CMD_W-1:0] duty_applied,
    output logic                    fault_latched
);

    logic [CMD_W-1:0] cnt, cnt_n, mag, duty_n;
    logic             sample, req_dir, rev, go, pend_dir, pend_dir_n, dir_n, pwm_n, latch_n;
    motor_state_e     state, state_n;

    pwm_period_counter #(.PERIOD(PERIOD)) u_cnt (
        .clk          (clk),
        .reset_n      (reset_n),
        .cnt          (cnt),
        .period_start (period_start),
        .sample       (sample)
    );

    assign cnt_n   = sample ? '0 : cnt + 1'b1;
    assign mag     = clamp_mag(duty_cmd, CMD_W'(PERIOD));
    // A zero command never asks for a reversal
    assign req_dir = (mag == '0) ? dir_out : duty_cmd[CMD_W-1];
    assign rev     = (mag != '0) && (req_dir != dir_out);
    // fault_latched can only be set while the FSM is forced to IDLE, so it gates IDLE exit alone
    assign go      = sample && (state != DEAD) && !fault_latched;

    always_comb begin
        state_n    = state;
        duty_n     = duty_applied;
        dir_n      = dir_out;
        pend_dir_n = pend_dir;
        if (!enable || fault) begin
            state_n = IDLE;
            duty_n  = '0;
        end else if (go) begin
            state_n    = rev ? DEAD : RUN;
            duty_n     = rev ? '0 : mag;
            pend_dir_n = req_dir;
        end else if (state == DEAD && cnt == CMD_W'(DEADTIME - 1)) begin
            state_n = HOLD;
            dir_n   = pend_dir;
        end
    end

    // Output registers are loaded with the value for the upcoming count
    assign pwm_n   = (state_n == RUN) && (cnt_n < duty_n);
    assign latch_n = enable && (fault_latched || fault);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            duty_applied  <= '0;
            dir_out       <= 1'b0;
            pend_dir      <= 1'b0;
            pwm_out       <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state         <= state_n;
            duty_applied  <= duty_n;
            dir_out       <= dir_n;
            pend_dir      <= pend_dir_n;
            pwm_out       <= pwm_n;
            fault_latched <= latch_n;
        end
    end

endmodule

// File: tb/tb_dc_motor_pwm_driver.sv
// tb_dc_motor_pwm_driver: period-plan reference model with per-cycle compare plus directed literal checks
module tb_dc_motor_pwm_driver;

    localparam int P  = 4000;
    localparam int DT = 200;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable = 1'b1;
    logic               fault = 1'b0;
    logic signed [15:0] duty_cmd = 16'sd1000;
    logic               pwm_out, dir_out, period_start, fault_latched;
    logic        [15:0] duty_applied;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dc_motor_pwm_driver #(.PERIOD(P), .DEADTIME(DT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .fault         (fault),
        .duty_cmd      (duty_cmd),
        .pwm_out       (pwm_out),
        .dir_out       (dir_out),
        .period_start  (period_start),
        .duty_applied  (duty_applied),
        .fault_latched (fault_latched)
    );

    // Model: each sample point fixes a plan for the whole next period
    // (kind 1 = drive m_duty, kind 2 = reversal to m_newdir); an abort idles the rest of it.
    int m_cnt = 0;
    int m_duty = 0;
    int m_kind = 0;
    bit m_wrapped = 0, m_dir = 0, m_latch = 0, m_abort = 1, m_newdir = 0;

    always @(posedge clk) begin : model_b
        int mag;
        bit rdir, latch_old, e_pwm, e_ps;
        int e_duty;
        if (!reset_n) begin
            m_cnt = 0; m_wrapped = 0; m_dir = 0; m_latch = 0; m_abort = 1; m_kind = 0; m_duty = 0;
        end else begin
            mag = int'(duty_cmd);
            mag = (mag < 0) ? -mag : mag;
            if (mag > P) mag = P;
            rdir = (mag == 0) ? m_dir : (duty_cmd < 0);
            latch_old = m_latch;
            if (!enable || fault) m_abort = 1;
            else if (m_cnt == P - 1) begin
                m_abort  = latch_old;
                m_kind   = (mag != 0 && rdir != m_dir) ? 2 : 1;
                m_duty   = mag;
                m_newdir = rdir;
            end
            m_latch = enable && (m_latch || fault);
            if (m_cnt == P - 1) m_wrapped = 1;
            m_cnt = (m_cnt == P - 1) ? 0 : m_cnt + 1;
            if (!m_abort && m_kind == 2 && m_cnt == DT) m_dir = m_newdir;
        end
        #1;
        e_pwm  = !m_abort && m_kind == 1 && m_cnt < m_duty;
        e_duty = (!m_abort && m_kind == 1) ? m_duty : 0;
        e_ps   = m_wrapped && m_cnt == 0;
        checks++;
        if (pwm_out !== e_pwm || dir_out !== m_dir || period_start !== e_ps ||
            fault_latched !== m_latch || duty_applied !== 16'(e_duty)) begin
            failures++;
            if (failures <= 10)
                $display("FAIL cycle_compare t=%0t cnt=%0d got pwm=%b dir=%b ps=%b flt=%b duty=%0d expected pwm=%b dir=%b ps=%b flt=%b duty=%0d",
                         $time, m_cnt, pwm_out, dir_out, period_start, fault_latched, duty_applied,
                         e_pwm, m_dir, e_ps, m_latch, e_duty);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Runs one period starting at a negedge with cnt == 0; optional command change, fault pulse, enable drop
    task automatic run_period(input int chg_at, input int chg_cmd, input int fault_at, input int en_off_at,
                              output int highs, output int flip_at, output int da0);
        logic d0;
        d0 = dir_out;
        highs = 0;
        flip_at = -1;
        da0 = int'(duty_applied);
        for (int i = 0; i < P; i++) begin
            highs += int'(pwm_out);
            if (dir_out !== d0 && flip_at < 0) flip_at = i;
            if (i == chg_at) duty_cmd = 16'(chg_cmd);
            fault  = (i == fault_at);
            enable = !(en_off_at >= 0 && i >= en_off_at && i < en_off_at + 2);
            @(negedge clk);
        end
    endtask

    initial begin
        int h, f, d;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_dir", int'(dir_out), 0);
        check("reset_ps", int'(period_start), 0);
        check("reset_duty", int'(duty_applied), 0);
        check("reset_flt", int'(fault_latched), 0);
        reset_n = 1'b1;
        run_period(-1, 0, -1, -1, h, f, d);
        check("first_period_idle", h, 0);
        run_period(2000, 3000, -1, -1, h, f, d);
        check("fwd1000_highs", h, 1000);
        check("fwd1000_duty", d, 1000);
        check("fwd1000_dir", int'(dir_out), 0);
        run_period(P - 1, 0, -1, -1, h, f, d);
        check("fwd3000_highs", h, 3000);
        run_period(P - 1, 500, -1, -1, h, f, d);
        check("zero_highs", h, 0);
        check("zero_noflip", f, -1);
        run_period(P - 1, -5000, -1, -1, h, f, d);
        check("fwd500_highs", h, 500);
        check("fwd500_dir", int'(dir_out), 0);
        run_period(-1, 0, -1, -1, h, f, d);
        check("rev_dead_highs", h, 0);
        check("rev_flip_at", f, DT);
        check("rev_dir", int'(dir_out), 1);
        run_period(P - 1, -32768, -1, -1, h, f, d);
        check("clamp5000_highs", h, P);
        check("clamp5000_duty", d, P);
        run_period(-1, 0, -1, -1, h, f, d);
        check("clamp32768_highs", h, P);
        run_period(-1, 0, 300, -1, h, f, d);
        check("fault_highs", h, 301);
        check("fault_latched_set", int'(fault_latched), 1);
        run_period(-1, 0, -1, 1000, h, f, d);
        check("fault_idle_highs", h, 0);
        check("fault_cleared", int'(fault_latched), 0);
        run_period(P - 1, 2000, -1, -1, h, f, d);
        check("resume_highs", h, P);
        for (int i = 0; i < 100; i++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrev_reset_dir", int'(dir_out), 0);
        check("midrev_reset_pwm", int'(pwm_out), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        run_period(-1, 0, -1, -1, h, f, d);
        check("post_reset_idle", h, 0);
        run_period(-1, 0, -1, -1, h, f, d);
        check("post_reset_highs", h, 2000);
        check("post_reset_noflip", f, -1);
        for (int i = 0; i < 3 * P; i++) begin
            if ($urandom_range(0, 799) == 0 || (i % P == P - 1 && $urandom_range(0, 1) == 1))
                duty_cmd = ($urandom_range(0, 9) == 0) ? 16'sh8000 : 16'(int'($urandom_range(0, 12000)) - 6000);
            fault = ($urandom_range(0, 4999) == 0);
            if ($urandom_range(0, 5999) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            @(negedge clk);
        end
        fault = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
